sample_framer: RTL and testbench
================================

# sample_framer

Capture front end between the ADC sampler and `shazam_core`. It takes the 12-bit unsigned ADC stream and decimates it by block averaging. Each decimated sample is converted to signed 16-bit and written into a ping-pong frame buffer. The buffer hands complete frames to the analysis core through a ready/done ownership handshake with a random-access read port.

## Interface

Parameters:
- `DECIM`, default 4: ADC samples averaged per output sample. Must be a power of two, from 1 to 16.
- `FRAME_LEN`, default 256: samples per frame. Must be a power of two.
- `ADDR_W`, default 8: equals log2(`FRAME_LEN`).

Ports:
- `clk`, in, 1: single system clock, 50 MHz.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse that arms capture.
- `adc_data`, in, 12: unsigned ADC sample, mid-scale 2048.
- `adc_data_valid`, in, 1: qualifies `adc_data` for one cycle.
- `frame_ready`, out, 1: bank `frame_bank` holds a complete frame owned by the consumer.
- `frame_bank`, out, 1: index of the bank being presented.
- `frame_done`, in, 1: one-cycle pulse from the consumer that releases the presented bank.
- `rd_addr`, in, `ADDR_W`: read address within the presented bank.
- `rd_data`, out, 16: signed sample read from `frame_bank` at `rd_addr`.
- `overrun`, out, 1: sticky flag, set when a frame is dropped.
- `busy`, out, 1: high while in CAPTURE.

## Operation

States are IDLE and CAPTURE.
- IDLE:
  - `adc_data_valid` is ignored.
  - A `start` pulse moves to CAPTURE and clears the accumulator, the decimation counter and the write address.
- CAPTURE:
  - Runs until `reset`.
  - `start` is ignored.

Decimation:
- Each valid sample adds to an accumulator of 12+log2(`DECIM`) bits.
- On the `DECIM`-th valid sample, `avg = sum >> log2(DECIM)` and the accumulator restarts.

Conversion:
- `s = (avg - 2048) <<< 4`, a signed 16-bit value.
- Range is -32768 (avg 0) to +32752 (avg 4095). The low 4 bits are always 0.

Buffer:
- Storage is 2×`FRAME_LEN`×16, as one RAM with one write port and one read port.
- Writes go to bank `wr_bank` at `wr_addr`, which increments by one per decimated sample.

When a write lands at `wr_addr` = `FRAME_LEN`-1 (frame complete), first evaluate the consumer as holding a bank if `frame_ready` = 1 and `frame_done` = 0 in that cycle. Then:
- If the consumer is not holding a bank:
  - Set `frame_ready` = 1 and `frame_bank` = `wr_bank`.
  - Toggle `wr_bank`.
  - Reset `wr_addr` to 0.
- If the consumer is holding a bank:
  - Set `overrun` = 1.
  - Keep `wr_bank` and `frame_bank` unchanged.
  - Reset `wr_addr` to 0. The next frame overwrites the same write bank, so the completed frame is dropped.
  - The presented bank is never written.

Release and read rules:
- A `frame_done` pulse with no completion in the same cycle clears `frame_ready` on the next cycle.
- A `frame_done` pulse while `frame_ready` = 0 is ignored.
- `rd_data` is defined only while `frame_ready` = 1. Otherwise it holds its last value.
- `overrun` clears only on `reset`.

Reset applies from any state and mid-frame:
- `frame_ready` = 0, `frame_bank` = 0, `overrun` = 0, `busy` = 0, `rd_data` = 0.
- `wr_bank` = 0, `wr_addr` = 0, accumulator = 0, state = IDLE.

## Timing

- `busy` rises the cycle after `start`.
- If the `DECIM`-th valid sample arrives in cycle t:
  - The converted sample is registered at the end of t.
  - It is written into RAM at the end of t+1.
- For the last sample of a frame, `frame_ready` and `frame_bank` update at the end of t+1 and are visible in cycle t+2.
- Read latency is 1 cycle: `rd_addr` presented in cycle n gives `rd_data` in cycle n+1. Back-to-back reads are allowed every cycle.
- `adc_data_valid` may be asserted every cycle with no gaps; throughput is 1 input sample per cycle.
- Completion and `frame_done` in the same cycle: `frame_ready` stays 1 and `frame_bank` flips in the same update, with no overrun.

## Test plan

1. **Mid-scale frame.** Reset, pulse `start`, then feed 1024 valid samples of 2048 with `DECIM`=4, one per cycle. Required: `frame_ready` rises 2 cycles after the 1024th valid sample, `frame_bank` = 0, and all 256 reads return 0 with 1-cycle latency.
2. **Conversion values.**
   - Input groups {4095×4} read back 32752 (0x7FF0).
   - Input groups {0×4} read back -32768 (0x8000).
   - Input groups {1000,1001,1002,1003} read back -16752.
   - Sample order within the frame matches arrival order.
3. **Normal ping-pong.** Pulse `frame_done` after frame 1, then complete frame 2. Required: `frame_ready` drops one cycle after `frame_done`; frame 2 is presented on `frame_bank` = 1; `overrun` = 0; bank 0 contents are overwritten only during frame 3.
4. **Overrun.** Never pulse `frame_done` and complete frames 2 and 3. Required:
   - Frame 2 fills bank 1; when it completes, `overrun` = 1 while `frame_ready` stays 1 and `frame_bank` stays 0.
   - Frame 3 is dropped. Bank 0 reads are unchanged throughout.
   - A later `frame_done` followed by the next completion presents bank 1.
5. **Simultaneous done and completion.** Pulse `frame_done` in the same cycle as a frame completion. Required: `frame_ready` stays 1 continuously, `frame_bank` toggles, `overrun` = 0.
6. **Reset and gating.**
   - Assert `reset` mid-frame, after 500 samples. Required: all outputs 0 on the next cycle.
   - Then drive valid samples with no `start`. Required: no writes occur and `busy` = 0.
   - Then pulse `start` and feed 1024 samples. Required: a full frame appears in bank 0, with no residue from the aborted frame.

Source files
------------

// File: rtl/sample_framer.sv
// sample_framer: block-averaging decimator for the 12-bit ADC stream, feeding a
// ping-pong frame buffer handed to the analysis core via a ready/done handshake.
module sample_framer #(
  parameter int DECIM     = 4,
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [11:0]       adc_data,
  input  logic              adc_data_valid,
  output logic              frame_ready,
  output logic              frame_bank,
  input  logic              frame_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic              overrun,
  output logic              busy
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = 12 + LOG2D;
  localparam int CNT_W = (LOG2D > 0) ? LOG2D : 1;

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [11:0]       avg;
  logic [15:0]       smp_q, smp_d;
  logic              smp_vld_q, smp_vld_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              frame_ready_q, frame_ready_d;
  logic              frame_bank_q, frame_bank_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       rd_data_q;
  logic              last_in;
  logic              complete;
  logic              holding;

  logic [15:0] mem [2*FRAME_LEN];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start) state_d = CAPTURE;
  end

  always_comb begin
    busy = (state_q == CAPTURE);
  end

  // Decimation, conversion, write addressing and the frame ownership handoff.
  always_comb begin
    sum           = acc_q + ACC_W'(adc_data);
    avg           = 12'(sum >> LOG2D);
    last_in       = (cnt_q == CNT_W'(DECIM - 1));
    complete      = smp_vld_q && (wr_addr_q == ADDR_W'(FRAME_LEN - 1));
    holding       = frame_ready_q && !frame_done;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    smp_d         = smp_q;
    smp_vld_d     = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_bank_d     = wr_bank_q;
    frame_ready_d = frame_ready_q;
    frame_bank_d  = frame_bank_q;
    overrun_d     = overrun_q;
    if (state_q == IDLE) begin
      if (start) begin
        acc_d     = '0;
        cnt_d     = '0;
        wr_addr_d = '0;
      end
    end else begin
      if (adc_data_valid) begin
        if (last_in) begin
          acc_d     = '0;
          cnt_d     = '0;
          // (avg - 2048) <<< 4 is just the offset-binary MSB flipped.
          smp_d     = {~avg[11], avg[10:0], 4'b0000};
          smp_vld_d = 1'b1;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (smp_vld_q) wr_addr_d = wr_addr_q + ADDR_W'(1);
    end
    if (complete) begin
      if (!holding) begin
        frame_ready_d = 1'b1;
        frame_bank_d  = wr_bank_q;
        wr_bank_d     = ~wr_bank_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (frame_done && frame_ready_q) begin
      frame_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      smp_q         <= '0;
      smp_vld_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_bank_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      smp_q         <= smp_d;
      smp_vld_q     <= smp_vld_d;
      wr_addr_q     <= wr_addr_d;
      wr_bank_q     <= wr_bank_d;
      frame_ready_q <= frame_ready_d;
      frame_bank_q  <= frame_bank_d;
      overrun_q     <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (smp_vld_q) mem[{wr_bank_q, wr_addr_q}] <= smp_q;
  end

  // Read port only updates while a frame is presented; otherwise it holds.
  always_ff @(posedge clk) begin
    if (reset)              rd_data_q <= '0;
    else if (frame_ready_q) rd_data_q <= mem[{frame_bank_q, rd_addr}];
  end

  assign frame_ready = frame_ready_q;
  assign frame_bank  = frame_bank_q;
  assign overrun     = overrun_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: directed test of decimation, conversion, ping-pong handoff,
// overrun, simultaneous release/completion and reset gating.
module tb_sample_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] adc_data;
  logic        adc_data_valid;
  logic        frame_ready;
  logic        frame_bank;
  logic        frame_done;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        overrun;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  sample_framer #(.DECIM(4), .FRAME_LEN(256), .ADDR_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .adc_data       (adc_data),
    .adc_data_valid (adc_data_valid),
    .frame_ready    (frame_ready),
    .frame_bank     (frame_bank),
    .frame_done     (frame_done),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pattern 0: mid-scale; 1: conversion table; >=2: per-frame ramp (pat*300 + group).
  function automatic logic [11:0] sampleVal(input int pat, input int j, input int k);
    int v;
    if (pat == 0) v = 2048;
    else if (pat == 1) begin
      case (j % 4)
        0:       v = 4095;
        1:       v = 0;
        2:       v = 1000 + k;
        default: v = 16 * j;
      endcase
    end else v = (pat * 300 + j) % 4096;
    return 12'(v);
  endfunction

  function automatic logic [15:0] expVal(input int pat, input int j);
    int v;
    if (pat == 0) return 16'h0000;
    if (pat == 1) begin
      case (j % 4)
        0:       return 16'h7FF0;
        1:       return 16'h8000;
        2:       return 16'hBE90;
        default: return 16'((16 * j - 2048) * 16);
      endcase
    end
    v = (pat * 300 + j) % 4096;
    return 16'((v - 2048) * 16);
  endfunction

  task automatic applyStimulus(input int pat, input int n);
    for (int s = 0; s < n; s++) begin
      adc_data       = sampleVal(pat, s / 4, s % 4);
      adc_data_valid = 1'b1;
      tick();
    end
    adc_data_valid = 1'b0;
  endtask

  task automatic readBank(input int pat, input string tag);
    for (int a = 0; a < 256; a++) begin
      rd_addr = 8'(a);
      tick();
      checkOutput($sformatf("%s[%0d]", tag, a), {16'h0, rd_data}, {16'h0, expVal(pat, a)});
    end
  endtask

  task automatic pulseDone();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    adc_data       = '0;
    adc_data_valid = 1'b0;
    frame_done     = 1'b0;
    rd_addr        = '0;
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("rst_ready",   32'(frame_ready), 0);
    checkOutput("rst_bank",    32'(frame_bank),  0);
    checkOutput("rst_overrun", 32'(overrun),     0);
    checkOutput("rst_busy",    32'(busy),        0);
    checkOutput("rst_rd_data", 32'(rd_data),     0);

    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 1);

    // Mid-scale frame lands in bank 0, ready two cycles after the last sample.
    applyStimulus(0, 1024);
    checkOutput("f1_ready_t1", 32'(frame_ready), 0);
    tick();
    checkOutput("f1_ready_t2", 32'(frame_ready), 1);
    checkOutput("f1_bank",     32'(frame_bank),  0);
    readBank(0, "f1_mid");
    pulseDone();
    checkOutput("f1_release", 32'(frame_ready), 0);

    // Conversion table frame in bank 1.
    applyStimulus(1, 1024);
    tick();
    checkOutput("f2_ready",   32'(frame_ready), 1);
    checkOutput("f2_bank",    32'(frame_bank),  1);
    checkOutput("f2_overrun", 32'(overrun),     0);
    readBank(1, "f2_conv");
    pulseDone();
    checkOutput("f2_release", 32'(frame_ready), 0);

    // Frame 3 overwrites bank 0.
    applyStimulus(2, 1024);
    tick();
    checkOutput("f3_ready", 32'(frame_ready), 1);
    checkOutput("f3_bank",  32'(frame_bank),  0);
    readBank(2, "f3_bank0");

    // Frame 4 completes in the same cycle as frame_done.
    applyStimulus(3, 1024);
    checkOutput("f4_ready_pre", 32'(frame_ready), 1);
    checkOutput("f4_bank_pre",  32'(frame_bank),  0);
    pulseDone();
    checkOutput("f4_ready_post", 32'(frame_ready), 1);
    checkOutput("f4_bank_post",  32'(frame_bank),  1);
    checkOutput("f4_overrun",    32'(overrun),     0);
    readBank(3, "f4_bank1");

    // Frames 5 and 6 complete while bank 1 is held: dropped, sticky overrun.
    applyStimulus(4, 1024);
    tick();
    checkOutput("f5_overrun", 32'(overrun),     1);
    checkOutput("f5_ready",   32'(frame_ready), 1);
    checkOutput("f5_bank",    32'(frame_bank),  1);
    readBank(3, "f5_keep");
    applyStimulus(5, 1024);
    tick();
    checkOutput("f6_ready", 32'(frame_ready), 1);
    checkOutput("f6_bank",  32'(frame_bank),  1);
    readBank(3, "f6_keep");
    pulseDone();
    checkOutput("f6_release", 32'(frame_ready), 0);
    applyStimulus(6, 1024);
    tick();
    checkOutput("f7_ready",   32'(frame_ready), 1);
    checkOutput("f7_bank",    32'(frame_bank),  0);
    checkOutput("f7_overrun", 32'(overrun),     1);
    readBank(6, "f7_bank0");

    // Reset mid-frame, then ungated samples must be ignored.
    applyStimulus(7, 500);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_ready",   32'(frame_ready), 0);
    checkOutput("mid_rst_bank",    32'(frame_bank),  0);
    checkOutput("mid_rst_overrun", 32'(overrun),     0);
    checkOutput("mid_rst_busy",    32'(busy),        0);
    checkOutput("mid_rst_rd_data", 32'(rd_data),     0);
    applyStimulus(8, 1024);
    tick();
    tick();
    checkOutput("gated_busy",  32'(busy),        0);
    checkOutput("gated_ready", 32'(frame_ready), 0);
    rd_addr = 8'd5;
    tick();
    checkOutput("gated_rd_hold", 32'(rd_data), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(9, 1024);
    checkOutput("f9_ready_t1", 32'(frame_ready), 0);
    tick();
    checkOutput("f9_ready",   32'(frame_ready), 1);
    checkOutput("f9_bank",    32'(frame_bank),  0);
    checkOutput("f9_overrun", 32'(overrun),     0);
    readBank(9, "f9_clean");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
